// File: rtl/id_hazard_controller.sv
// rtl/id_hazard_controller.sv - ID-stage issue/hold/flush sequencing with in-flight destination scoreboard
module id_hazard_controller #(
  parameter int FORWARD_EN = 1,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] dest,
  input  logic             wb_en,
  input  logic             mem_r_en,
  input  logic             br_taken,
  input  logic             mem_stall,
  output logic             freeze,
  output logic             bubble,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } slot_t;

  slot_t exe_q, mem_q, wb_q, exe_d;

  logic match_exe, match_mem, match_wb;
  logic hazard, hazard_stall, issue;

  // r0 is never a real producer, so it is excluded from every match
  function automatic logic src_match(
    input slot_t            s,
    input logic [REG_W-1:0] s1,
    input logic [REG_W-1:0] s2,
    input logic             use_s2
  );
    return s.valid && s.wb_en && (s.dest != '0) &&
           ((s.dest == s1) || (use_s2 && (s.dest == s2)));
  endfunction

  assign match_exe = src_match(exe_q, src1, src2, two_src);
  assign match_mem = src_match(mem_q, src1, src2, two_src);
  assign match_wb  = src_match(wb_q,  src1, src2, two_src);

  // With forwarding only a load still in EXE cannot be bypassed in time
  assign hazard = id_valid &&
                  ((FORWARD_EN != 0) ? (match_exe && exe_q.mem_r_en)
                                     : (match_exe || match_mem || match_wb));

  assign hazard_stall = !rst && !mem_stall && !br_taken && hazard;
  assign issue        = id_valid && !mem_stall && !br_taken && !hazard;

  always_comb begin
    freeze   = 1'b0;
    bubble   = 1'b0;
    if_flush = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        freeze = 1'b1;
      end else if (br_taken) begin
        if_flush = 1'b1;
        bubble   = 1'b1;
      end else if (hazard) begin
        freeze = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  always_comb begin
    exe_d = '0;
    if (issue) begin
      exe_d.valid    = 1'b1;
      exe_d.dest     = dest;
      exe_d.wb_en    = wb_en;
      exe_d.mem_r_en = mem_r_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q        <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      stall_cycles <= '0;
    end else begin
      if (!mem_stall) begin
        wb_q  <= mem_q;
        mem_q <= exe_q;
        exe_q <= exe_d;
      end
      if (hazard_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/id_hazard_controller.md
# id_hazard_controller

Sequencing controller for the ID stage: tracks destination registers of instructions in flight in EXE, MEM and WB, and decides each cycle whether the instruction currently in ID may issue, must be held (freeze IF/ID and PC, bubble into ID/EXE) or must be discarded because of a taken branch. It sits beside the ID stage and drives the pipeline-register enables and flush lines. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface

- FORWARD_EN, 0, 1: forwarding unit present, only load-use hazards stall; 0: stall on any RAW match in EXE/MEM/WB
- REG_W, 5, register-index width
- CNT_W, 16, stall counter width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- src1  in  REG_W  first source register of ID instruction
- src2  in  REG_W  second source register of ID instruction
- two_src  in  1  ID instruction reads src2 (register-type or store)
- dest  in  REG_W  destination of ID instruction
- wb_en  in  1  ID instruction writes dest
- mem_r_en  in  1  ID instruction is a load
- br_taken  in  1  branch resolved taken in EXE this cycle
- mem_stall  in  1  memory not ready; entire pipeline holds
- freeze  out  1  hold PC and IF/ID register
- bubble  out  1  load NOP into ID/EXE instead of ID instruction
- if_flush  out  1  clear IF/ID (wrong-path instruction)
- stall_cycles  out  CNT_W  count of cycles with freeze=1, saturating

## Operation

- Scoreboard: three slots EXE, MEM, WB, each {valid, dest, wb_en, mem_r_en}. All fields 0 on reset.
- Register 0 never creates a hazard (writes to r0 are discarded by the register file).
- Source match for slot S: S.valid & S.wb_en & S.dest != 0 & (S.dest == src1 | (two_src & S.dest == src2)).
- hazard (combinational), qualified by id_valid:
  - FORWARD_EN=1: match in EXE with EXE.mem_r_en=1 only.
  - FORWARD_EN=0: match in EXE, MEM or WB (register file written at WB edge, so WB must be included).
- Priority, highest first:
  1. mem_stall=1: freeze=1, bubble=0, if_flush=0; scoreboard holds; counter does not increment.
  2. br_taken=1: if_flush=1, bubble=1, freeze=0; ID instruction discarded (not entered into scoreboard), regardless of hazard.
  3. hazard=1: freeze=1, bubble=1.
  4. otherwise all three 0; ID instruction issues.
- Scoreboard update when mem_stall=0: WB<=MEM, MEM<=EXE, EXE<={id_valid, dest, wb_en, mem_r_en} if issued, else all-zero.
- stall_cycles increments by 1 on each rising edge where hazard-caused freeze applied (case 3); holds at 2^CNT_W-1; no wrap. mem_stall freezes are not counted.

## Timing

- freeze, bubble, if_flush combinational from current inputs and scoreboard; no added latency. All 0 while rst=1 (scoreboard empty, inputs ignored for counter).
- stall_cycles registered; 0 on reset; updates one edge after the stalled cycle.
- Load-use stall length: exactly 1 cycle with FORWARD_EN=1.
- FORWARD_EN=0: producer immediately ahead stalls 3 cycles; one gap instruction, 2; two gap instructions, 1; three or more, 0.
- br_taken and hazard in same cycle: flush only, no freeze, no count.
- mem_stall during a hazard stall: stall length extended by the mem_stall cycles; scoreboard frozen so hazard persists unchanged.
- rst asserted mid-stall: outputs drop to 0 immediately; scoreboard and counter cleared asynchronously.

## Test plan

- FORWARD_EN=1: load r3 issues, next cycle ADD r5=r3+r4 in ID -> freeze=bubble=1 for exactly 1 cycle, then issue; stall_cycles=1.
- FORWARD_EN=0: ADD r2 issues, next ID reads r2 -> freeze high 3 cycles; with one NOP between -> 2 cycles; two NOPs -> 1; three -> 0.
- Producer writes r0, consumer reads r0 -> no freeze in either FORWARD_EN setting; two_src=0 with src2 matching EXE.dest -> no freeze.
- Hazard present and br_taken=1 same cycle -> if_flush=1, bubble=1, freeze=0; next cycle EXE slot empty; stall_cycles unchanged.
- mem_stall=1 for 4 cycles in middle of a 3-cycle FORWARD_EN=0 stall -> freeze continuous 7 cycles, stall_cycles=3, scoreboard contents identical before/after mem_stall.
- CNT_W=4, force 20 hazard cycles -> stall_cycles saturates at 15; assert rst mid-stall -> freeze=0 and stall_cycles=0 before next clock edge.
